// File: rtl/clock_period_meter.sv
// clock_period_meter
// Measures the period and high time of a slow square wave in basys_clk
// cycles, and reports the divider setting m that would reproduce it.
// One measurement per accepted start; results hold until the next success.
//
// Ports:
//   basys_clk  in   system clock (only clock in the block)
//   reset      in   asynchronous, active-high reset
//   start      in   one-cycle measurement request, ignored while busy
//   sig_in     in   signal under measurement, asynchronous
//   busy       out  measurement in progress
//   done       out  one-cycle pulse on successful completion
//   timeout    out  sticky abort flag, cleared by the next accepted start
//   period     out  cycles between successive rising edges
//   high_time  out  cycles from rising edge to following falling edge
//   m_est      out  equivalent divider setting, (period>>1)-1 floored at 0
//
// state | meaning
// IDLE  | waiting for start, results held
// ARM   | waiting for the first clean rising edge
// HIGH  | counting the high phase, waiting for the falling edge
// LOW   | counting the low phase, waiting for the closing rising edge

module clock_period_meter #(
    parameter logic [31:0] TIMEOUT = 32'd100_000_000
) (
    input  logic        basys_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sig_in,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] period,
    output logic [31:0] high_time,
    output logic [31:0] m_est
);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    state_t      state, state_nxt;
    logic        sig_m, sig_s, sig_d;
    logic        rise, fall, expired;
    logic [31:0] cnt, cnt_nxt;
    logic        busy_nxt, done_nxt, timeout_nxt;
    logic [31:0] period_nxt, high_nxt, m_nxt;

    always_ff @(posedge basys_clk or posedge reset) begin
        if (reset) begin
            sig_m <= 1'b0;
            sig_s <= 1'b0;
            sig_d <= 1'b0;
        end else begin
            sig_m <= sig_in;
            sig_s <= sig_m;
            sig_d <= sig_s;
        end
    end

    assign rise    = sig_s & ~sig_d;
    assign fall    = ~sig_s & sig_d;
    // >= rather than == so an ignored strobe landing on the limit cannot
    // let the counter run past it.
    assign expired = (cnt >= TIMEOUT);

    always_ff @(posedge basys_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            period    <= '0;
            high_time <= '0;
            m_est     <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            timeout   <= timeout_nxt;
            period    <= period_nxt;
            high_time <= high_nxt;
            m_est     <= m_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        timeout_nxt = timeout;
        period_nxt  = period;
        high_nxt    = high_time;
        m_nxt       = m_est;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = ARM;
                    busy_nxt    = 1'b1;
                    timeout_nxt = 1'b0;
                    cnt_nxt     = '0;
                end
            end
            ARM: begin
                if (rise) begin
                    // the rise cycle itself is the first cycle of the period
                    cnt_nxt   = 32'd1;
                    state_nxt = HIGH;
                end else if (expired) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            HIGH: begin
                if (fall) begin
                    high_nxt  = cnt;
                    cnt_nxt   = cnt + 32'd1;
                    state_nxt = LOW;
                end else if (expired) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            LOW: begin
                if (rise) begin
                    state_nxt  = IDLE;
                    period_nxt = cnt;
                    m_nxt      = (cnt < 32'd2) ? 32'd0 : (cnt >> 1) - 32'd1;
                    done_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                end else if (expired) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter: stimulus pushes expected
// (period, high_time, m_est) triples, a monitor pops one on every done.
module tb_clock_period_meter;

    logic        basys_clk = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic        sig_in    = 1'b0;
    logic        busy, done, timeout;
    logic [31:0] period, high_time, m_est;

    clock_period_meter #(.TIMEOUT(32'd1000)) dut (
        .basys_clk (basys_clk),
        .reset     (reset),
        .start     (start),
        .sig_in    (sig_in),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .period    (period),
        .high_time (high_time),
        .m_est     (m_est)
    );

    always #5 basys_clk = ~basys_clk;

    typedef struct {
        logic [31:0] p;
        logic [31:0] h;
        logic [31:0] m;
    } exp_t;

    exp_t exp_q[$];
    int   tests    = 0;
    int   failed   = 0;
    int   done_cnt = 0;

    // square-wave source: gen_hi cycles high, gen_lo cycles low
    logic gen_en = 1'b0;
    int   gen_hi = 8;
    int   gen_lo = 8;
    int   ph     = 0;

    initial begin
        forever begin
            @(posedge basys_clk);
            #1;
            if (!gen_en) begin
                sig_in = 1'b0;
                ph     = 0;
            end else begin
                sig_in = (ph < gen_hi);
                ph     = ph + 1;
                if (ph >= gen_hi + gen_lo) ph = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge basys_clk) begin
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            if (exp_q.size() == 0) begin
                tests  = tests + 1;
                failed = failed + 1;
                $display("FAIL unexpected_done: got done with period %0d, expected no done", period);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("period", period, e.p);
                chk("high_time", high_time, e.h);
                chk("m_est", m_est, e.m);
                chk("timeout_at_done", {31'd0, timeout}, 32'd0);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge basys_clk);
    endtask

    task automatic pulse_start();
        @(negedge basys_clk);
        start = 1'b1;
        @(negedge basys_clk);
        start = 1'b0;
    endtask

    task automatic expect_meas(input logic [31:0] p, input logic [31:0] h, input logic [31:0] m);
        exp_t e;
        e.p = p;
        e.h = h;
        e.m = m;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget);
        int c0;
        int n;
        c0 = done_cnt;
        n  = 0;
        while (done_cnt == c0 && n < budget) begin
            @(posedge basys_clk);
            #1;
            n = n + 1;
        end
        if (done_cnt == c0) begin
            tests  = tests + 1;
            failed = failed + 1;
            $display("FAIL %s: got no done within %0d cycles, expected a done", name, budget);
        end
    endtask

    task automatic wait_sig(input logic level, input int budget);
        int n;
        n = 0;
        while (sig_in !== level && n < budget) begin
            @(posedge basys_clk);
            #1;
            n = n + 1;
        end
        if (sig_in !== level) begin
            tests  = tests + 1;
            failed = failed + 1;
            $display("FAIL wait_sig: got sig_in %b, expected %b", sig_in, level);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        chk({tag, "_period"}, period, 32'd0);
        chk({tag, "_high_time"}, high_time, 32'd0);
        chk({tag, "_m_est"}, m_est, 32'd0);
    endtask

    initial begin
        int n;
        int c0;

        cycles(3);
        check_all_zero("reset");
        @(negedge basys_clk);
        reset = 1'b0;

        // divider loopback m=7
        gen_hi = 8; gen_lo = 8; gen_en = 1'b1;
        cycles(5);
        expect_meas(32'd16, 32'd8, 32'd7);
        pulse_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_done("m7_done", 100);

        // fastest signal m=0
        gen_hi = 1; gen_lo = 1;
        cycles(5);
        expect_meas(32'd2, 32'd1, 32'd0);
        pulse_start();
        wait_done("m0_done", 50);

        // asymmetric duty 3/9, started while sig_in low
        gen_hi = 3; gen_lo = 9;
        cycles(20);
        wait_sig(1'b0, 20);
        expect_meas(32'd12, 32'd3, 32'd5);
        pulse_start();
        wait_done("asym_done", 60);

        // same signal, armed while the synchronized signal is already high
        cycles(2);
        wait_sig(1'b0, 20);
        wait_sig(1'b1, 20);
        cycles(2);
        expect_meas(32'd12, 32'd3, 32'd5);
        pulse_start();
        wait_done("asym_partial_done", 60);

        // start while busy: no restart, exactly one done
        gen_hi = 8; gen_lo = 8;
        cycles(20);
        c0 = done_cnt;
        expect_meas(32'd16, 32'd8, 32'd7);
        pulse_start();
        cycles(12);
        pulse_start();
        chk("busy_after_2nd_start", {31'd0, busy}, 32'd1);
        wait_done("busy_start_done", 100);
        cycles(40);
        chk("busy_start_done_count", 32'(done_cnt - c0), 32'd1);

        // timeout with sig_in held low
        gen_en = 1'b0;
        cycles(6);
        pulse_start();
        chk("busy_to_start", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(posedge basys_clk);
            #1;
            n = n + 1;
        end
        chk("timeout_latency", 32'(n), 32'd1001);
        chk("timeout_flag", {31'd0, timeout}, 32'd1);
        chk("kept_period", period, 32'd16);
        chk("kept_high_time", high_time, 32'd8);
        chk("kept_m_est", m_est, 32'd7);

        // next start clears timeout and measures normally
        gen_en = 1'b1;
        cycles(5);
        expect_meas(32'd16, 32'd8, 32'd7);
        pulse_start();
        chk("timeout_cleared", {31'd0, timeout}, 32'd0);
        wait_done("after_timeout_done", 100);

        // reset during LOW
        cycles(3);
        pulse_start();
        wait_sig(1'b0, 40);
        wait_sig(1'b1, 40);
        wait_sig(1'b0, 40);
        cycles(5);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        cycles(2);
        reset = 1'b0;
        cycles(3);
        expect_meas(32'd16, 32'd8, 32'd7);
        pulse_start();
        wait_done("post_reset_done", 100);

        cycles(40);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the period and high time of a slow clock-like signal in `basys_clk` cycles. It is the inverse of the flexible clock divider: the divider turns a count `m` into a clock, and this block turns a clock back into the `m` that would reproduce it. It sits beside divider instances for self-check and on-board debug, and can also characterise any external square wave. One measurement runs per `start` request; results are held until the next successful measurement.

## Interface
Parameters:
- `TIMEOUT`, default 32'd100_000_000: abort limit in `basys_clk` cycles (1 s at 100 MHz). Legal range is 2 to 2^32-1.

Ports:
- `basys_clk`  input  1  system clock; the only clock in the block.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  single-cycle request to begin a measurement; ignored while `busy`=1.
- `sig_in`  input  1  signal under measurement; asynchronous to `basys_clk`.
- `busy`  output  1  high from acceptance of `start` until the measurement completes or aborts.
- `done`  output  1  one-cycle pulse when a measurement completes successfully.
- `timeout`  output  1  sticky abort flag; cleared by the next accepted `start`.
- `period`  output  32  cycles between two successive rising edges of `sig_in`.
- `high_time`  output  32  cycles from a rising edge to the following falling edge.
- `m_est`  output  32  divider setting equivalent to the measured signal: `(period>>1) - 1`, saturated at 0.

## Operation
Input conditioning:
- Two-flop synchronizer produces `sig_s`; a third flop produces `sig_d`. All three reset to 0.
- `rise = sig_s & ~sig_d`; `fall = ~sig_s & sig_d`. Both are combinational strobes.

State machine (states IDLE, ARM, HIGH, LOW):
- **IDLE**: `busy`=0. On `start`: go to ARM, set `busy`=1, clear `timeout`, set `cnt`=0.
- **ARM**: wait for `rise`. If `sig_in` is already high when armed, the block waits for the next rising edge; a partial high phase is never measured.
  - On `rise`: `cnt`<=1, go to HIGH.
  - Otherwise `cnt` increments.
- **HIGH**: `cnt` increments each cycle. On `fall`: `high_time`<=`cnt`, go to LOW.
- **LOW**: `cnt` increments each cycle. On `rise`, go to IDLE and in the same cycle:
  - `period`<=`cnt`
  - `m_est`<=`(cnt>>1)-1`, or 0 if `cnt`<2
  - `done`<=1 for one cycle
  - `busy`<=0
- **Timeout** (ARM, HIGH, LOW): when `cnt`==`TIMEOUT` and no edge strobe is active that cycle, go to IDLE with `timeout`<=1 and `busy`<=0. `period`, `high_time` and `m_est` keep their previous values. If an edge strobe and the timeout condition occur in the same cycle, the edge wins.

Width and arithmetic rules:
- `cnt` is 32 bits and cannot wrap, because the timeout fires first.
- `high_time` is latched immediately, but the outputs only represent a consistent measurement when `done` pulses.

Other rules:
- `start` while `busy`=1 is ignored: no restart, no flag change.
- Reset at any point: state goes to IDLE; `busy`, `done`, `timeout`, `period`, `high_time`, `m_est` and `cnt` all go to 0; synchronizer flops go to 0.

## Timing
- All outputs are registered. Reset values are all 0.
- `sig_in` edge (meeting setup) to strobe: the strobe is visible after the 2nd `basys_clk` edge. The registered update (state, latches, `done`) occurs at the 3rd edge.
- `busy` rises on the edge that samples `start`. `done` and the falling edge of `busy` coincide.
- A measurement spans at most one full period after the first rise plus the wait in ARM. `done` occurs at most 3 cycles after the second `sig_in` rising edge.
- Minimum measurable signal: high ≥ 1 cycle and low ≥ 1 cycle, as seen after synchronization.

## Test plan
- **Divider loopback, m=7**: a divider driven from `basys_clk` feeds `sig_in`; pulse `start` → `done` pulse with `period`=16, `high_time`=8, `m_est`=7, `timeout`=0.
- **Fastest signal, m=0**: divider with m=0 (toggles every cycle) → `period`=2, `high_time`=1, `m_est`=0.
- **Asymmetric duty**: `sig_in` high 3 cycles, low 9 cycles → `period`=12, `high_time`=3, `m_est`=5. Repeat with `start` asserted while `sig_in` is high → identical results (no partial phase measured).
- **Timeout**: `TIMEOUT`=1000, `sig_in` held low → `busy` drops and `timeout`=1 exactly 1000 cycles after the first ARM cycle; no `done`; previous results retained. A subsequent `start` clears `timeout`.
- **Start while busy**: pulse `start` again mid-HIGH → no restart; a single `done` with the correct values.
- **Reset mid-measure**: assert `reset` in LOW → all outputs 0 immediately. After release, a fresh `start` measures m=7 correctly.
